// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, signed or unsigned, one quotient bit per clock.
// Latency: result_o/ready_o valid WIDTH+1 edges after acceptance (2 edges for divide-by-zero).
// Handshake: start_i is held until ready_o is consumed; dropping start_i in END frees the unit.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   signed_div_i    1 = two's-complement division, 0 = unsigned
//   opdata1_i       dividend, sampled only at the accepting edge
//   opdata2_i       divisor, sampled only at the accepting edge
//   start_i         request, held high until the result is consumed
//   annul_i         abort of an in-flight division
//   result_o        {remainder, quotient}, registered
//   ready_o         result_o valid, registered
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  // dvd starts as the dividend magnitude; quotient bits shift in from the LSB
  // as dividend bits shift out of the MSB, so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd, dvd_n;
  logic [WIDTH-1:0] dsr, dsr_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic             neg_q, neg_q_n;   // operand signs differed (signed mode only)
  logic             neg_r, neg_r_n;   // dividend was negative (signed mode only)
  logic [WIDTH-1:0] quo_fin, quo_fin_n;
  logic [WIDTH-1:0] rem_fin, rem_fin_n;
  logic [2*WIDTH-1:0] result_n;
  logic             ready_n;

  // One restoring step, evaluated every cycle and used only in ON.
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  always_comb begin
    trial    = {rem, dvd[WIDTH-1]} - {1'b0, dsr};
    qbit     = ~trial[WIDTH];
    rem_step = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
    quo_step = {dvd[WIDTH-2:0], qbit};
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dvd_n     = dvd;
    dsr_n     = dsr;
    rem_n     = rem;
    neg_q_n   = neg_q;
    neg_r_n   = neg_r;
    quo_fin_n = quo_fin;
    rem_fin_n = rem_fin;
    result_n  = result_o;
    ready_n   = ready_o;

    case (state)
      FREE: begin
        result_n = '0;
        ready_n  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = BYZERO;
          end else begin
            // Magnitudes are taken mod 2^WIDTH; the most-negative value maps
            // to itself, which is its correct unsigned magnitude.
            dvd_n   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
            dsr_n   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
            rem_n   = '0;
            cnt_n   = '0;
            neg_q_n = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r_n = signed_div_i & opdata1_i[WIDTH-1];
            state_n = ON;
          end
        end
      end

      BYZERO: begin
        quo_fin_n = '0;
        rem_fin_n = '0;
        state_n   = END;
      end

      ON: begin
        if (annul_i) begin
          state_n = FREE;
        end else begin
          dvd_n = quo_step;
          rem_n = rem_step;
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            quo_fin_n = neg_q ? -quo_step : quo_step;
            rem_fin_n = neg_r ? -rem_step : rem_step;
            state_n   = END;
          end
        end
      end

      END: begin
        if (start_i) begin
          ready_n  = 1'b1;
          result_n = {rem_fin, quo_fin};
        end else begin
          ready_n  = 1'b0;
          result_n = '0;
          state_n  = FREE;
        end
      end

      default: begin
        state_n  = FREE;
        ready_n  = 1'b0;
        result_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      quo_fin  <= '0;
      rem_fin  <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dvd      <= dvd_n;
      dsr      <= dsr_n;
      rem      <= rem_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      quo_fin  <= quo_fin_n;
      rem_fin  <= rem_fin_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: a 32-bit and an 8-bit instance share clock and reset.
// Stimulus pushes expected {result, ready cycle} into per-instance queues;
// a negedge monitor pops and compares on every rising ready_o.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sgn32, start32, annul32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        rdy32;

  logic        sgn8, start8, annul8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        rdy8;

  div_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sgn32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(rdy32)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(rdy8)
  );

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  logic prev32 = 1'b0;
  logic prev8  = 1'b0;
  exp_t m32, m8;
  always @(negedge clk) begin
    if (rdy32 && !prev32) begin
      if (q32.size() == 0) begin
        chk("unexpected_rdy32", 64'(rdy32), 64'd0);
      end else begin
        m32 = q32.pop_front();
        chk("res32", res32, m32.res);
        chk("lat32", 64'(cyc), 64'(m32.cyc));
      end
    end
    if (rdy8 && !prev8) begin
      if (q8.size() == 0) begin
        chk("unexpected_rdy8", 64'(rdy8), 64'd0);
      end else begin
        m8 = q8.pop_front();
        chk("res8", 64'(res8), m8.res);
        chk("lat8", 64'(cyc), 64'(m8.cyc));
      end
    end
    prev32 = rdy32;
    prev8  = rdy8;
  end

  // Issue returns at the negedge after the accepting edge, with operands scrambled.
  task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e, input int lat, input bit push);
    exp_t x;
    @(negedge clk);
    sgn32 = s; a32 = a; b32 = b; start32 = 1'b1; annul32 = 1'b0;
    if (push) begin
      x.res = e;
      x.cyc = cyc + 1 + lat;
      q32.push_back(x);
    end
    @(negedge clk);
    a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom);
  endtask

  task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] e, input int lat);
    exp_t x;
    @(negedge clk);
    sgn8 = s; a8 = a; b8 = b; start8 = 1'b1; annul8 = 1'b0;
    x.res = 64'(e);
    x.cyc = cyc + 1 + lat;
    q8.push_back(x);
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
  endtask

  task automatic wait_rdy(input bit w8);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((w8 ? rdy8 : rdy32) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk(w8 ? "timeout8" : "timeout32", 64'd0, 64'd1);
  endtask

  task automatic release32();
    start32 = 1'b0;
    @(negedge clk);
    chk("rdy32_drop", 64'(rdy32), 64'd0);
    chk("res32_drop", res32, 64'd0);
  endtask

  task automatic release8();
    start8 = 1'b0;
    @(negedge clk);
    chk("rdy8_drop", 64'(rdy8), 64'd0);
  endtask

  task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] e, input int lat);
    issue32(s, a, b, e, lat, 1'b1);
    wait_rdy(1'b0);
    release32();
  endtask

  function automatic logic [15:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, q, r;
    if (b == 8'd0) return 16'h0000;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[7:0], q[7:0]};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [7:0]  ra, rb;
    logic        rs;
    rst = 1'b1;
    sgn32 = 0; a32 = 0; b32 = 0; start32 = 0; annul32 = 0;
    sgn8 = 0; a8 = 0; b8 = 0; start8 = 0; annul8 = 0;
    #1;
    chk("reset_rdy32", 64'(rdy32), 64'd0);
    chk("reset_res32", res32, 64'd0);
    chk("reset_rdy8", 64'(rdy8), 64'd0);
    chk("reset_res8", 64'(res8), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed 32-bit vectors.
    op32(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    op32(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
    op32(1'b1, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 33);
    op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    op32(1'b0, 32'd7, 32'd100, {32'd7, 32'd0}, 33);
    op32(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
    op32(1'b0, 32'd5, 32'd0, 64'd0, 2);
    op32(1'b1, 32'd5, 32'd0, 64'd0, 2);

    // Annul sampled at E10: no result, then a fresh divide with full latency.
    issue32(1'b0, 32'd100, 32'd7, 64'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    annul32 = 1'b1;
    @(negedge clk);
    annul32 = 1'b0;
    start32 = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= rdy32;
    end
    chk("annul_no_rdy", 64'(seen), 64'd0);
    op32(1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33);

    // Reset while END holds a result: outputs clear without a clock edge.
    issue32(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1);
    wait_rdy(1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_end_rdy32", 64'(rdy32), 64'd0);
    chk("rst_end_res32", res32, 64'd0);
    start32 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset between E5 and E6, then 9/3 with full latency.
    issue32(1'b0, 32'd100, 32'd7, 64'd0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_on_rdy32", 64'(rdy32), 64'd0);
    chk("rst_on_res32", res32, 64'd0);
    start32 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    op32(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // 8-bit instance: directed vector then model-checked sweep per mode.
    issue8(1'b0, 8'd200, 8'd9, {8'd2, 8'd22}, 9);
    wait_rdy(1'b1);
    release8();
    for (int i = 0; i < 2000; i++) begin
      rs = (i >= 1000);
      ra = 8'($urandom);
      rb = (i % 97 == 0) ? 8'd0 : 8'($urandom);
      issue8(rs, ra, rb, model8(rs, ra, rb), (rb == 8'd0) ? 2 : 9);
      wait_rdy(1'b1);
      release8();
    end

    repeat (3) @(negedge clk);
    chk("q32_empty", 64'(q32.size()), 64'd0);
    chk("q8_empty", 64'(q8.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
